udp_tx_hdr_gen: RTL and testbench

//  User-side transmit front end for the Ethernet MAC+FIFO top. Forwards the UDP payload AXI-Stream into the tx FIFO

---
 rtl/udp_tx_hdr_gen.sv | 233 +++++++++++++++++++++++
 tb/tb_udp_tx_hdr_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_hdr_gen.sv
// udp_tx_hdr_gen: UDP transmit front end.
// - Forwards the payload AXI-Stream to the tx FIFO write port with no added latency.
// - Counts the payload bytes and builds the UDP checksum over the pseudo-header,
//   the UDP header and the payload.
// - Once per packet, presents UDP length, IP total length and checksum on a
//   valid/ready header interface.
// Optional feature macro: UDP_CHECKSUM_EN. When it is undefined, no accumulator
// is built and the checksum output is 0x0000 (IPv4 "no checksum"). The FSM and
// its timing are the same in both builds.
module udp_tx_hdr_gen #(
  parameter int AXI_DATA_WIDTH = 8,     // only 8 is supported
  parameter int MAX_PAYLOAD    = 1472
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_trdy,
  output logic [AXI_DATA_WIDTH-1:0] m_tx_axis_tdata,
  output logic                      m_tx_axis_tvalid,
  output logic                      m_tx_axis_tlast,
  input  logic                      m_tx_axis_trdy,
  input  logic [31:0]               i_src_ip,
  input  logic [31:0]               i_dst_ip,
  input  logic [15:0]               i_src_port,
  input  logic [15:0]               i_dst_port,
  output logic                      m_hdr_tvalid,
  output logic [15:0]               m_udp_hdr_length,
  output logic [15:0]               m_udp_hdr_checksum,
  output logic [15:0]               m_ip_hdr_length,
  input  logic                      s_hdr_trdy,
  output logic                      o_oversize
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_FINAL,
    S_FOLD1,
    S_FOLD2,
    S_HDR
  } state_e;

  localparam logic [31:0] MAX_BYTES = MAX_PAYLOAD;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [15:0] ip_len_q, ip_len_d;
  logic [15:0] csum_q, csum_d;

  logic        in_open;
  logic        in_hs;
  logic        hdr_hs;
  logic [15:0] udp_len;
  logic [15:0] ip_len;
  logic [15:0] csum_final;

  // The payload path is open only in IDLE/STREAM. It is also held shut while
  // reset is applied, so no beat can be handed to the FIFO during reset.
  assign in_open          = ~i_reset && ((state_q == S_IDLE) || (state_q == S_STREAM));
  assign s_axis_trdy      = m_tx_axis_trdy & in_open;
  assign m_tx_axis_tvalid = s_axis_tvalid & in_open;
  assign m_tx_axis_tdata  = s_axis_tdata;
  assign m_tx_axis_tlast  = s_axis_tlast;

  assign in_hs  = s_axis_tvalid & s_axis_trdy;
  assign hdr_hs = hdr_valid_q & s_hdr_trdy;

  assign udp_len = count_q + 16'd8;
  assign ip_len  = count_q + 16'd28;

  assign o_oversize = (state_q == S_FINAL) && ({16'h0000, count_q} > MAX_BYTES);

  assign m_hdr_tvalid       = hdr_valid_q;
  assign m_udp_hdr_length   = udp_len_q;
  assign m_ip_hdr_length    = ip_len_q;
  assign m_udp_hdr_checksum = csum_q;

  // Next-state logic: stream the payload, then run the fixed 3-cycle finish and hold the header.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_hs) state_d = s_axis_tlast ? S_FINAL : S_STREAM;
      S_STREAM: if (in_hs && s_axis_tlast) state_d = S_FINAL;
      S_FINAL:  state_d = S_FOLD1;
      S_FOLD1:  state_d = S_FOLD2;
      S_FOLD2:  state_d = S_HDR;
      S_HDR:    if (hdr_hs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Payload byte counter: cleared on the way back to IDLE and saturating at 0xFFFF.
  always_comb begin
    count_d = count_q;
    if (hdr_hs) begin
      count_d = '0;
    end else if (in_hs && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Header outputs: loaded on the first HDR cycle and held until the consumer accepts them.
  always_comb begin
    hdr_valid_d = hdr_valid_q;
    udp_len_d   = udp_len_q;
    ip_len_d    = ip_len_q;
    csum_d      = csum_q;
    if ((state_q == S_HDR) && !hdr_valid_q) begin
      hdr_valid_d = 1'b1;
      udp_len_d   = udp_len;
      ip_len_d    = ip_len;
      csum_d      = csum_final;
    end else if (hdr_hs) begin
      hdr_valid_d = 1'b0;
    end
  end

  // Control and header registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      hdr_valid_q <= 1'b0;
      udp_len_q   <= '0;
      ip_len_q    <= '0;
      csum_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // samples the values from before the clock edge.
      state_q     <= state_d;
      count_q     <= count_d;
      hdr_valid_q <= hdr_valid_d;
      udp_len_q   <= udp_len_d;
      ip_len_q    <= ip_len_d;
      csum_q      <= csum_d;
    end
  end

`ifdef UDP_CHECKSUM_EN
  logic [31:0]               sum_q, sum_d;
  logic                      odd_q, odd_d;        // a high byte is waiting for its partner
  logic [AXI_DATA_WIDTH-1:0] hi_q, hi_d;
  logic [31:0]               src_ip_q, src_ip_d;
  logic [31:0]               dst_ip_q, dst_ip_d;
  logic [15:0]               src_port_q, src_port_d;
  logic [15:0]               dst_port_q, dst_port_d;
  logic [31:0]               final_add;
  logic [15:0]               sum_inv;

  // Words added in FINAL: the pseudo-header, the UDP header (checksum field = 0)
  // and the zero-padded trailing byte of an odd-length payload.
  assign final_add = {16'h0000, src_ip_q[31:16]} + {16'h0000, src_ip_q[15:0]}
                   + {16'h0000, dst_ip_q[31:16]} + {16'h0000, dst_ip_q[15:0]}
                   + 32'h0000_0011
                   + {16'h0000, udp_len} + {16'h0000, udp_len}
                   + {16'h0000, src_port_q} + {16'h0000, dst_port_q}
                   + (odd_q ? {16'h0000, hi_q, {AXI_DATA_WIDTH{1'b0}}} : 32'h0);

  assign sum_inv    = ~sum_q[15:0];
  assign csum_final = (sum_inv == 16'h0000) ? 16'hFFFF : sum_inv;

  // Checksum accumulator: pairs bytes big-endian, adds the headers, then folds twice.
  always_comb begin
    sum_d      = sum_q;
    odd_d      = odd_q;
    hi_d       = hi_q;
    src_ip_d   = src_ip_q;
    dst_ip_d   = dst_ip_q;
    src_port_d = src_port_q;
    dst_port_d = dst_port_q;
    case (state_q)
      S_IDLE, S_STREAM: begin
        if (in_hs) begin
          if (odd_q) begin
            sum_d = sum_q + {16'h0000, hi_q, s_axis_tdata};
            odd_d = 1'b0;
          end else begin
            hi_d  = s_axis_tdata;
            odd_d = 1'b1;
          end
          if (state_q == S_IDLE) begin
            src_ip_d   = i_src_ip;
            dst_ip_d   = i_dst_ip;
            src_port_d = i_src_port;
            dst_port_d = i_dst_port;
          end
        end
      end
      S_FINAL: sum_d = sum_q + final_add;
      S_FOLD1, S_FOLD2: sum_d = {16'h0000, sum_q[15:0]} + {16'h0000, sum_q[31:16]};
      S_HDR: begin
        if (hdr_hs) begin
          sum_d = '0;
          odd_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Checksum datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sum_q      <= '0;
      odd_q      <= 1'b0;
      hi_q       <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      src_port_q <= '0;
      dst_port_q <= '0;
    end else begin
      sum_q      <= sum_d;
      odd_q      <= odd_d;
      hi_q       <= hi_d;
      src_ip_q   <= src_ip_d;
      dst_ip_q   <= dst_ip_d;
      src_port_q <= src_port_d;
      dst_port_q <= dst_port_d;
    end
  end
`else
  // The address and port inputs only feed the checksum, so this build leaves them unused.
  logic unused_hdr_fields;
  assign unused_hdr_fields = ^{i_src_ip, i_dst_ip, i_src_port, i_dst_port};
  assign csum_final        = 16'h0000;
`endif

endmodule

// File: tb/tb_udp_tx_hdr_gen.sv
// Testbench for udp_tx_hdr_gen. It follows the UDP_CHECKSUM_EN macro of the
// build, and expects a checksum of 0x0000 when the macro is undefined.
module tb_udp_tx_hdr_gen;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_trdy;
  logic [7:0]  m_tx_axis_tdata;
  logic        m_tx_axis_tvalid;
  logic        m_tx_axis_tlast;
  logic        m_tx_axis_trdy;
  logic [31:0] i_src_ip;
  logic [31:0] i_dst_ip;
  logic [15:0] i_src_port;
  logic [15:0] i_dst_port;
  logic        m_hdr_tvalid;
  logic [15:0] m_udp_hdr_length;
  logic [15:0] m_udp_hdr_checksum;
  logic [15:0] m_ip_hdr_length;
  logic        s_hdr_trdy;
  logic        o_oversize;

  always #5 i_clk = ~i_clk;

  udp_tx_hdr_gen dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_trdy        (s_axis_trdy),
    .m_tx_axis_tdata    (m_tx_axis_tdata),
    .m_tx_axis_tvalid   (m_tx_axis_tvalid),
    .m_tx_axis_tlast    (m_tx_axis_tlast),
    .m_tx_axis_trdy     (m_tx_axis_trdy),
    .i_src_ip           (i_src_ip),
    .i_dst_ip           (i_dst_ip),
    .i_src_port         (i_src_port),
    .i_dst_port         (i_dst_port),
    .m_hdr_tvalid       (m_hdr_tvalid),
    .m_udp_hdr_length   (m_udp_hdr_length),
    .m_udp_hdr_checksum (m_udp_hdr_checksum),
    .m_ip_hdr_length    (m_ip_hdr_length),
    .s_hdr_trdy         (s_hdr_trdy),
    .o_oversize         (o_oversize)
  );

`ifdef UDP_CHECKSUM_EN
  localparam logic [15:0] CS_MASK = 16'hFFFF;
`else
  localparam logic [15:0] CS_MASK = 16'h0000;
`endif

  typedef struct {
    int          len;
    logic [63:0] data;   // payload bytes, first byte in the top bits
    logic [31:0] sip, dip;
    logic [15:0] sp, dp, ul, il, cs;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  int pkt_no = 0;

  logic [7:0]  pkt_q[$];
  logic [7:0]  rx_q[$];
  int          rx_last_cnt;
  int          rx_last_pos;
  int          ovs_cnt = 0;
  logic [31:0] cur_sip, cur_dip;
  logic [15:0] cur_sp, cur_dp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Monitor: collect the bytes handed to the FIFO and count oversize pulses.
  always @(negedge i_clk) begin
    if (!i_reset && m_tx_axis_tvalid && m_tx_axis_trdy) begin
      if (m_tx_axis_tlast) begin
        rx_last_cnt++;
        rx_last_pos = rx_q.size();
      end
      rx_q.push_back(m_tx_axis_tdata);
    end
    if (o_oversize) ovs_cnt++;
  end

  // Reference: lay out pseudo-header + UDP header + payload as bytes and take
  // the one's-complement sum of the big-endian 16-bit words.
  function automatic void model_hdr(output logic [15:0] ul, output logic [15:0] il,
                                    output logic [15:0] cs);
    logic [7:0]      msg[$];
    logic [159:0]    hdr;
    longint unsigned s;
    logic [15:0]     r;
    int              n;
    n   = pkt_q.size();
    ul  = 16'(n + 8);
    il  = 16'(n + 28);
    hdr = {cur_sip, cur_dip, 8'h00, 8'd17, ul, cur_sp, cur_dp, ul, 16'h0000};
    for (int i = 0; i < 20; i++) msg.push_back(hdr[159-8*i -: 8]);
    for (int i = 0; i < n; i++) msg.push_back(pkt_q[i]);
    if (msg.size() % 2 != 0) msg.push_back(8'h00);
    s = 0;
    for (int i = 0; i < msg.size(); i += 2) s += {48'h0, msg[i], msg[i+1]};
    while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
    r  = ~s[15:0];
    cs = ((r == 16'h0000) ? 16'hFFFF : r) & CS_MASK;
  endfunction

  task automatic load_vec(input vec_t v);
    logic [63:0] d;
    d = v.data;
    pkt_q.delete();
    for (int i = 0; i < v.len; i++) pkt_q.push_back(d[63-8*i -: 8]);
    cur_sip = v.sip;
    cur_dip = v.dip;
    cur_sp  = v.sp;
    cur_dp  = v.dp;
  endtask

  // Drives pkt_q; mode 0: FIFO always ready, 1: ready toggles 1010.., 2: random.
  task automatic send_pkt(input int mode, input bit scramble, input string tag);
    int mirror_bad = 0;
    int stuck      = 0;
    bit tog        = 1'b1;
    bit got;
    int cyc;
    i_src_ip   = cur_sip;
    i_dst_ip   = cur_dip;
    i_src_port = cur_sp;
    i_dst_port = cur_dp;
    for (int i = 0; i < pkt_q.size(); i++) begin
      s_axis_tdata  = pkt_q[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == pkt_q.size() - 1);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 200) begin
        m_tx_axis_trdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
        tog = ~tog;
        @(negedge i_clk);
        if (s_axis_trdy !== m_tx_axis_trdy) mirror_bad++;
        got = s_axis_trdy;
        @(posedge i_clk);
        #1;
        cyc++;
      end
      if (!got) stuck++;
      if (i == 0 && scramble) begin
        i_src_ip   = $urandom;
        i_dst_ip   = $urandom;
        i_src_port = 16'($urandom);
        i_dst_port = 16'($urandom);
      end
    end
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    m_tx_axis_trdy = 1'b1;
    check({tag, "_trdy_mirror"}, mirror_bad, 0);
    check({tag, "_beat_timeout"}, stuck, 0);
  endtask

  // Called at 1 time unit after the tlast edge: the header must appear on the 4th edge.
  task automatic wait_hdr(input logic [15:0] ul, input logic [15:0] il, input logic [15:0] cs,
                          input string tag);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (m_hdr_tvalid) break;
    end
    check({tag, "_hdr_latency"}, k, 4);
    check({tag, "_udp_len"}, m_udp_hdr_length, ul);
    check({tag, "_ip_len"}, m_ip_hdr_length, il);
    check({tag, "_checksum"}, m_udp_hdr_checksum, cs);
  endtask

  task automatic accept_hdr(input int stall, input logic [15:0] ul, input logic [15:0] il,
                            input logic [15:0] cs, input string tag);
    int bad = 0;
    for (int s = 0; s < stall; s++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (!m_hdr_tvalid || m_udp_hdr_length !== ul || m_ip_hdr_length !== il ||
          m_udp_hdr_checksum !== cs || s_axis_trdy || m_tx_axis_tvalid) bad++;
    end
    if (stall > 0) check({tag, "_hdr_hold"}, bad, 0);
    @(posedge i_clk);
    #1;
    s_hdr_trdy = 1'b1;
    @(posedge i_clk);
    #1;
    s_hdr_trdy = 1'b0;
    check({tag, "_hdr_drop"}, m_hdr_tvalid, 0);
  endtask

  task automatic rx_clear();
    rx_q.delete();
    rx_last_cnt = 0;
    rx_last_pos = -1;
  endtask

  task automatic check_rx(input string tag);
    int errs = 0;
    if (rx_q.size() != pkt_q.size()) errs++;
    for (int i = 0; i < rx_q.size() && i < pkt_q.size(); i++)
      if (rx_q[i] !== pkt_q[i]) errs++;
    if (rx_last_cnt != 1) errs++;
    if (rx_last_pos != pkt_q.size() - 1) errs++;
    check({tag, "_fifo_bytes"}, errs, 0);
  endtask

  task automatic run_pkt(input int mode, input bit scramble, input int stall,
                         input logic [15:0] ul, input logic [15:0] il, input logic [15:0] cs);
    string tag;
    tag = $sformatf("p%0d", pkt_no);
    pkt_no++;
    rx_clear();
    send_pkt(mode, scramble, tag);
    wait_hdr(ul, il, cs, tag);
    accept_hdr(stall, ul, il, cs, tag);
    check_rx(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lengths"}, {m_udp_hdr_length, m_ip_hdr_length}, 32'h0);
    check({tag, "_checksum"}, m_udp_hdr_checksum, 0);
    check({tag, "_flags"}, {m_hdr_tvalid, o_oversize, s_axis_trdy, m_tx_axis_tvalid}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[5];
    logic [15:0] ul, il, cs;
    string       tag;

    // {len, payload, src ip, dst ip, src port, dst port, udp len, ip len, checksum}
    vt[0] = '{3, 64'h0102_0300_0000_0000, 32'hC0A8010A, 32'hC0A80114, 16'h1234, 16'h5678,
              16'h000B, 16'h001F, 16'h0FBB};
    vt[1] = '{1, 64'hFF00_0000_0000_0000, 32'h0, 32'h0, 16'h0000, 16'h0000,
              16'h0009, 16'h001D, 16'h00DC};
    vt[2] = '{2, 64'h1234_0000_0000_0000, 32'h01020304, 32'h05060708, 16'h0001, 16'h0002,
              16'h000A, 16'h001E, 16'hDD8F};
    vt[3] = '{2, 64'hFFDA_0000_0000_0000, 32'h0, 32'h0, 16'h0000, 16'h0000,
              16'h000A, 16'h001E, 16'hFFFF};
    vt[4] = '{4, 64'hFFFF_FFFF_0000_0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 16'hFFFF,
              16'h000C, 16'h0020, 16'hFFD6};

    i_reset        = 1'b1;
    s_axis_tdata   = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    m_tx_axis_trdy = 1'b1;
    i_src_ip       = '0;
    i_dst_ip       = '0;
    i_src_port     = '0;
    i_dst_port     = '0;
    s_hdr_trdy     = 1'b0;
    rx_clear();

    @(negedge i_clk);
    check_reset_outputs("reset");
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    // T1 plus table vectors: fixed expectations, FIFO always ready.
    for (int v = 0; v < 5; v++) begin
      load_vec(vt[v]);
      run_pkt(0, 1'b0, 0, vt[v].ul, vt[v].il, vt[v].cs & CS_MASK);
    end

    // T2: FIFO backpressure 1010..., header values identical to T1.
    load_vec(vt[0]);
    run_pkt(1, 1'b0, 0, vt[0].ul, vt[0].il, vt[0].cs & CS_MASK);

    // T3: header held for 10 cycles while the next packet is already offered.
    load_vec(vt[0]);
    tag = $sformatf("p%0d", pkt_no);
    pkt_no++;
    rx_clear();
    send_pkt(0, 1'b0, tag);
    wait_hdr(vt[0].ul, vt[0].il, vt[0].cs & CS_MASK, tag);
    @(posedge i_clk);
    #1;
    s_axis_tdata  = 8'hAA;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    accept_hdr(10, vt[0].ul, vt[0].il, vt[0].cs & CS_MASK, tag);
    check_rx(tag);
    pkt_q   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    cur_sip = 32'h0A000001;
    cur_dip = 32'h0A000002;
    cur_sp  = 16'h0400;
    cur_dp  = 16'h0035;
    model_hdr(ul, il, cs);
    run_pkt(0, 1'b0, 0, ul, il, cs);

    // T5: reset after 5 of 10 bytes with the inputs still active, then T1 again.
    m_tx_axis_trdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_axis_tdata  = 8'(8'h30 + i);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b0;
      @(posedge i_clk);
      #1;
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    check_reset_outputs("mid_reset");
    @(posedge i_clk);
    #1;
    i_reset       = 1'b0;
    s_axis_tvalid = 1'b0;
    @(posedge i_clk);
    #1;
    load_vec(vt[0]);
    run_pkt(0, 1'b0, 0, vt[0].ul, vt[0].il, vt[0].cs & CS_MASK);

    // T4: 1473 bytes gives one oversize pulse; 1472 bytes gives none.
    pkt_q.delete();
    for (int i = 0; i < 1473; i++) pkt_q.push_back(8'($urandom));
    cur_sip = 32'hC0A8010A;
    cur_dip = 32'hC0A80114;
    cur_sp  = 16'h1234;
    cur_dp  = 16'h5678;
    model_hdr(ul, il, cs);
    ovs_cnt = 0;
    run_pkt(0, 1'b0, 0, 16'h05C9, 16'h05DD, cs);
    check("oversize_1473_pulses", ovs_cnt, 1);
    void'(pkt_q.pop_back());
    model_hdr(ul, il, cs);
    ovs_cnt = 0;
    run_pkt(0, 1'b0, 0, 16'h05C8, 16'h05DC, cs);
    check("oversize_1472_pulses", ovs_cnt, 0);

    // Random packets with random backpressure and header stalls. The address and
    // port inputs change after the first beat, so only the first beat's values may be used.
    for (int p = 0; p < 24; p++) begin
      pkt_q.delete();
      for (int i = 0; i < $urandom_range(1, 40); i++) pkt_q.push_back(8'($urandom));
      cur_sip = $urandom;
      cur_dip = $urandom;
      cur_sp  = 16'($urandom);
      cur_dp  = 16'($urandom);
      model_hdr(ul, il, cs);
      run_pkt(2, 1'b1, $urandom_range(0, 3), ul, il, cs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
